// File: rtl/ark_keysched.sv
// AddRoundKey with in-place AES-128 key expansion; ark_out is registered one cycle after accept.
// ark_ready drops while the next round key expands (4 cycles word-serial, 1 cycle when ARK_FAST_EN is defined).
module ark_keysched #(
    parameter int NROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         ark_enable,
    input  logic [127:0] data,
    output logic [127:0] ark_out,
    output logic         ark_valid,
    output logic         ark_ready,
    output logic [3:0]   round_num,
    output logic         last_round
);
    typedef enum logic [1:0] {IDLE, READY, EXPAND, DONE} state_t;

    localparam logic [3:0] LAST = 4'(NROUNDS);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[2047 - 8*int'(x) -: 8];
    endfunction

    // Key word c is column c of the row-major state: row 0 byte in the MSBs.
    function automatic logic [31:0] col_get(input logic [127:0] s, input int c);
        logic [31:0] w;
        w = '0;
        for (int r = 0; r < 4; r++)
            w[31-8*r -: 8] = s[127-8*(4*r+c) -: 8];
        return w;
    endfunction

    function automatic logic [127:0] col_set(input logic [127:0] s, input int c, input logic [31:0] w);
        logic [127:0] t;
        t = s;
        for (int r = 0; r < 4; r++)
            t[127-8*(4*r+c) -: 8] = w[31-8*r -: 8];
        return t;
    endfunction

    state_t        state, state_nxt;
    logic [127:0]  rk, rk_nxt;
    logic [7:0]    rcon, rcon_nxt;
    logic          accept, expand_last;
    logic [31:0]   w0, w3, sub_rot, w0_new;

    assign w0       = col_get(rk, 0);
    assign w3       = col_get(rk, 3);
    assign sub_rot  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    assign w0_new   = w0 ^ sub_rot ^ {rcon, 24'h000000};
    assign rcon_nxt = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);

`ifdef ARK_FAST_EN
    logic [31:0] w1, w2, w1_new, w2_new, w3_new;

    assign w1          = col_get(rk, 1);
    assign w2          = col_get(rk, 2);
    assign w1_new      = w1 ^ w0_new;
    assign w2_new      = w2 ^ w1_new;
    assign w3_new      = w3 ^ w2_new;
    assign rk_nxt      = col_set(col_set(col_set(col_set(rk, 0, w0_new), 1, w1_new), 2, w2_new), 3, w3_new);
    assign expand_last = 1'b1;
`else
    logic [1:0]  widx, widx_prev;
    logic [31:0] w_cur, w_prev, w_new;

    // w3 is only rewritten on the last step, so SubWord on the first step sees the old w3.
    assign widx_prev   = widx - 2'd1;
    assign w_cur       = col_get(rk, int'(widx));
    assign w_prev      = col_get(rk, int'(widx_prev));
    assign w_new       = (widx == 2'd0) ? w0_new : (w_cur ^ w_prev);
    assign rk_nxt      = col_set(rk, int'(widx), w_new);
    assign expand_last = (widx == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            widx <= 2'd0;
        else if (start || accept)
            widx <= 2'd0;
        else if (state == EXPAND)
            widx <= widx + 2'd1;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ark_ready = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: ;
            READY: begin
                ark_ready = 1'b1;
                if (ark_enable) begin
                    accept    = 1'b1;
                    state_nxt = (round_num == LAST) ? DONE : EXPAND;
                end
            end
            EXPAND: begin
                if (expand_last)
                    state_nxt = READY;
            end
            DONE: ;
        endcase
        if (start) begin
            accept    = 1'b0;
            state_nxt = READY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rk         <= '0;
            rcon       <= 8'h01;
            round_num  <= 4'd0;
            ark_out    <= '0;
            ark_valid  <= 1'b0;
            last_round <= 1'b0;
        end else begin
            ark_valid  <= 1'b0;
            last_round <= 1'b0;
            if (start) begin
                rk        <= key_in;
                rcon      <= 8'h01;
                round_num <= 4'd0;
            end else if (accept) begin
                ark_out    <= data ^ rk;
                ark_valid  <= 1'b1;
                last_round <= (round_num == LAST);
            end else if (state == EXPAND) begin
                rk <= rk_nxt;
                if (expand_last) begin
                    round_num <= round_num + 4'd1;
                    rcon      <= rcon_nxt;
                end
            end
        end
    end

endmodule
